// File: rtl/dram_sequencer.sv
// dram_sequencer
//    Generates DRAM RAS/CAS/address-mux timing from Z80 bus strobes for
//    one RAM slot. It also runs refresh cycles from the Z80 refresh
//    indicator. A precharge phase of TRP clocks follows every row cycle.
//    A request that arrives during precharge is held in a single pending
//    slot, and it starts without passing through IDLE.
//
//    Optional feature: define VG8020_REFRESH_CNT_EN to build the 7-bit
//    refresh row counter. Without that macro, rfsh_row is tied to 0.
//
// Ports
//    clk       in   sequencer clock
//    rst       in   asynchronous active-high reset
//    nmreq     in   Z80 memory request (active low)
//    nrd       in   Z80 read strobe (active low)
//    nwr       in   Z80 write strobe (active low)
//    nrfshd    in   Z80 refresh indicator (active low)
//    nsltsl3   in   RAM slot select (active low)
//    nras      out  DRAM row strobe (active low)
//    mux       out  address mux select (0 = row, 1 = column)
//    ncas      out  DRAM column strobe (active low)
//    busy      out  high whenever the sequencer is not idle
//    rfsh_row  out  refresh row counter
module dram_sequencer #(
   parameter int TRP = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       nmreq,
   input  logic       nrd,
   input  logic       nwr,
   input  logic       nrfshd,
   input  logic       nsltsl3,
   output logic       nras,
   output logic       mux,
   output logic       ncas,
   output logic       busy,
   output logic [6:0] rfsh_row
);

   typedef enum logic [2:0] {IDLE, ROW, COL, CAS, REF, PRE} state_t;

   localparam logic [2:0] TRP_CNT = 3'(TRP);

   state_t     state_reg, state_next;
   logic [2:0] pre_cnt_reg, pre_cnt_next;
   logic       pend_ref_reg, pend_ref_next;
   logic       pend_acc_reg, pend_acc_next;
   logic       nras_next, mux_next, ncas_next, busy_next;

   // Refresh takes priority over an access, so a memory access is only
   // recognised when nrfshd is high.
   logic ref_req, acc_req;
   assign ref_req = !nmreq && !nrfshd;
   assign acc_req = !nmreq && !nsltsl3 && nrfshd;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         pre_cnt_reg  <= 3'd0;
         pend_ref_reg <= 1'b0;
         pend_acc_reg <= 1'b0;
         nras         <= 1'b1;
         mux          <= 1'b0;
         ncas         <= 1'b1;
         busy         <= 1'b0;
      end else begin
         state_reg    <= state_next;
         pre_cnt_reg  <= pre_cnt_next;
         pend_ref_reg <= pend_ref_next;
         pend_acc_reg <= pend_acc_next;
         nras         <= nras_next;
         mux          <= mux_next;
         ncas         <= ncas_next;
         busy         <= busy_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      pre_cnt_next  = pre_cnt_reg;
      pend_ref_next = pend_ref_reg;
      pend_acc_next = pend_acc_reg;

      case (state_reg)
         IDLE: begin
            if (ref_req)      state_next = REF;
            else if (acc_req) state_next = ROW;
         end
         ROW: state_next = nmreq ? PRE : COL;
         COL: state_next = nmreq ? PRE : CAS;
         CAS: if (nmreq) state_next = PRE;
         REF: if (nmreq) state_next = PRE;
         PRE: begin
            if (pre_cnt_reg >= TRP_CNT) begin
               // Last precharge cycle. A latched or current request starts
               // at once, but only while nmreq is still asserted.
               pre_cnt_next  = 3'd0;
               pend_ref_next = 1'b0;
               pend_acc_next = 1'b0;
               if (!nmreq && (pend_ref_reg || ref_req))
                  state_next = REF;
               else if (!nmreq && (pend_acc_reg || acc_req))
                  state_next = ROW;
               else
                  state_next = IDLE;
            end else begin
               pre_cnt_next = pre_cnt_reg + 3'd1;
               if (ref_req)
                  pend_ref_next = 1'b1;
               else if (acc_req)
                  pend_acc_next = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase

      // The first precharge cycle counts as cycle 1.
      if (state_next == PRE && state_reg != PRE)
         pre_cnt_next = 3'd1;

      // Outputs decode the state being entered, so they change on the
      // same edge as the state register.
      nras_next = !(state_next inside {ROW, COL, CAS, REF});
      mux_next  = state_next inside {COL, CAS};
      ncas_next = !(state_next == CAS && (!nrd || !nwr));
      busy_next = (state_next != IDLE);
   end

`ifdef VG8020_REFRESH_CNT_EN
   logic [6:0] rfsh_row_reg;
   logic       ref_done;

   // A refresh cycle counts once it reaches precharge.
   assign ref_done = (state_reg == REF) && nmreq;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rfsh_row_reg <= 7'd0;
      else if (ref_done)
         rfsh_row_reg <= rfsh_row_reg + 7'd1;
   end

   assign rfsh_row = rfsh_row_reg;
`else
   assign rfsh_row = 7'd0;
`endif

endmodule

// File: tb/tb_dram_sequencer.sv
// tb_dram_sequencer
//    Scoreboard bench for dram_sequencer. Each driven cycle steps a
//    behavioural model (phase + age counters) and queues the expected
//    outputs. A monitor compares them one edge later. Directed sections
//    cover read timing, refresh, counter wrap, back-to-back requests,
//    unselected requests and asynchronous reset. A randomized section
//    follows them.
module tb_dram_sequencer;
   localparam int TRP = 2;

`ifdef VG8020_REFRESH_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   typedef logic [10:0] exp_t;   // {nras, mux, ncas, busy, rfsh_row}

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       nmreq = 1'b1, nrd = 1'b1, nwr = 1'b1, nrfshd = 1'b1, nsltsl3 = 1'b1;
   logic       nras, mux, ncas, busy;
   logic [6:0] rfsh_row;

   dram_sequencer #(.TRP(TRP)) dut (
      .clk(clk), .rst(rst), .nmreq(nmreq), .nrd(nrd), .nwr(nwr),
      .nrfshd(nrfshd), .nsltsl3(nsltsl3), .nras(nras), .mux(mux),
      .ncas(ncas), .busy(busy), .rfsh_row(rfsh_row)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   txn      = 0;
   exp_t exp_q[$];
   exp_t mon_e, mon_a;

   // Reference model: 0 idle, 1 access (age 0 row, 1 column, 2+ cas),
   // 2 refresh, 3 precharge (m_pre_left cycles remaining).
   int   m_mode, m_age, m_pre_left, m_pend, m_row;
   logic m_strobe_idle;

   task automatic model_reset();
      m_mode = 0; m_age = 0; m_pre_left = 0; m_pend = 0; m_row = 0;
      m_strobe_idle = 1'b1;
   endtask

   task automatic model_step(input logic a_nmreq, a_nrd, a_nwr, a_nrfshd, a_nsltsl3);
      bit want_ref, want_acc;
      want_ref = !a_nmreq && !a_nrfshd;
      want_acc = !a_nmreq && !a_nsltsl3;
      case (m_mode)
         0: begin
            if (want_ref) m_mode = 2;
            else if (want_acc) begin m_mode = 1; m_age = 0; end
         end
         1, 2: begin
            if (a_nmreq) begin
               if (m_mode == 2 && CNT_EN) m_row = (m_row + 1) % 128;
               m_mode = 3; m_pre_left = TRP; m_pend = 0;
            end else if (m_mode == 1 && m_age < 2) begin
               m_age = m_age + 1;
            end
         end
         default: begin
            if (m_pre_left == 1) begin
               if (!a_nmreq && (m_pend == 2 || want_ref)) m_mode = 2;
               else if (!a_nmreq && (m_pend == 1 || want_acc)) begin m_mode = 1; m_age = 0; end
               else m_mode = 0;
               m_pend = 0;
            end else begin
               m_pre_left = m_pre_left - 1;
               if (want_ref) m_pend = 2;
               else if (want_acc && m_pend != 2) m_pend = 1;
            end
         end
      endcase
      m_strobe_idle = a_nrd & a_nwr;
   endtask

   function automatic exp_t model_out();
      logic [6:0] r;
      r = 7'(m_row);
      case (m_mode)
         0: return {4'b1010, r};
         1: begin
            if (m_age == 0)      return {4'b0011, r};
            else if (m_age == 1) return {4'b0111, r};
            else                 return {2'b01, m_strobe_idle, 1'b1, r};
         end
         2: return {4'b0011, r};
         default: return {4'b1011, r};
      endcase
   endfunction

   // Drive one cycle of inputs at the falling edge and queue the outputs
   // expected after the following rising edge.
   task automatic drive(input logic a_nmreq, a_nrd, a_nwr, a_nrfshd, a_nsltsl3);
      @(negedge clk);
      nmreq = a_nmreq; nrd = a_nrd; nwr = a_nwr; nrfshd = a_nrfshd; nsltsl3 = a_nsltsl3;
      model_step(a_nmreq, a_nrd, a_nwr, a_nrfshd, a_nsltsl3);
      exp_q.push_back(model_out());
   endtask

   task automatic after_edge();
      @(posedge clk);
      #2;
   endtask

   task automatic chk1(input string name, input logic act, input logic req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %b, required %b", name, act, req);
      end
   endtask

   task automatic chk7(input string name, input logic [6:0] act, input logic [6:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // Monitor: the DUT presents fresh outputs on every rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {nras, mux, ncas, busy, rfsh_row};
            n_checks++;
            txn++;
            if (mon_a !== mon_e) begin
               n_fail++;
               $display("FAIL scoreboard txn %0d: got nras/mux/ncas/busy=%b row=%0d, required %b row=%0d",
                        txn, mon_a[10:7], mon_a[6:0], mon_e[10:7], mon_e[6:0]);
            end else begin
               $display("txn %0d nras=%b mux=%b ncas=%b busy=%b row=%0d",
                        txn, mon_a[10], mon_a[9], mon_a[8], mon_a[7], mon_a[6:0]);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   logic r_nmreq;

   initial begin
      model_reset();
      #1 rst = 1'b1;
      #2;
      chk1("reset_nras", nras, 1'b1);
      chk1("reset_mux", mux, 1'b0);
      chk1("reset_ncas", ncas, 1'b1);
      chk1("reset_busy", busy, 1'b0);
      chk7("reset_row", rfsh_row, 7'd0);
      repeat (2) @(posedge clk);
      #2 chk1("reset_hold_busy", busy, 1'b0);
      @(negedge clk) rst = 1'b0;

      // Read access
      drive(1, 1, 1, 1, 1);
      drive(0, 0, 1, 1, 0); after_edge();
      chk1("read_row_nras", nras, 1'b0);
      chk1("read_row_mux", mux, 1'b0);
      drive(0, 0, 1, 1, 0); after_edge();
      chk1("read_col_mux", mux, 1'b1);
      chk1("read_col_ncas", ncas, 1'b1);
      drive(0, 0, 1, 1, 0); after_edge();
      chk1("read_cas_ncas", ncas, 1'b0);
      drive(0, 0, 1, 1, 0);
      drive(1, 1, 1, 1, 1); after_edge();
      chk1("read_pre_nras", nras, 1'b1);
      chk1("read_pre_ncas", ncas, 1'b1);
      chk1("read_pre_busy", busy, 1'b1);
      drive(1, 1, 1, 1, 1); after_edge();
      chk1("read_pre2_busy", busy, 1'b1);
      drive(1, 1, 1, 1, 1); after_edge();
      chk1("read_idle_busy", busy, 1'b0);

      // Refresh with slot deselected
      repeat (3) begin
         drive(0, 1, 1, 0, 1); after_edge();
         chk1("ref_nras", nras, 1'b0);
         chk1("ref_mux", mux, 1'b0);
         chk1("ref_ncas", ncas, 1'b1);
      end
      drive(1, 1, 1, 1, 1); after_edge();
      chk7("ref_row_after", rfsh_row, CNT_EN ? 7'd1 : 7'd0);
      repeat (TRP) drive(1, 1, 1, 1, 1);

      // Counter wrap: 127 more refresh cycles bring the row back to 0
      for (int i = 0; i < 127; i++) begin
         drive(0, 1, 1, 0, 1);
         drive(1, 1, 1, 1, 1);
         if (i == 125) begin
            after_edge();
            chk7("ref_row_127", rfsh_row, CNT_EN ? 7'd127 : 7'd0);
         end
         repeat (TRP) drive(1, 1, 1, 1, 1);
      end
      chk7("ref_row_wrap", rfsh_row, 7'd0);

      // Unselected request stays idle
      repeat (4) begin
         drive(0, 1, 1, 1, 1); after_edge();
         chk1("unsel_nras", nras, 1'b1);
         chk1("unsel_busy", busy, 1'b0);
      end
      drive(1, 1, 1, 1, 1);

      // Back-to-back: request raised in first precharge cycle and held
      repeat (3) drive(0, 0, 1, 1, 0);
      drive(1, 1, 1, 1, 1);
      drive(0, 0, 1, 1, 0); after_edge();
      chk1("b2b_pre_nras", nras, 1'b1);
      drive(0, 0, 1, 1, 0); after_edge();
      chk1("b2b_row_nras", nras, 1'b0);
      chk1("b2b_row_mux", mux, 1'b0);
      chk1("b2b_row_busy", busy, 1'b1);
      drive(0, 0, 1, 1, 0);
      drive(1, 1, 1, 1, 1);
      // Request dropped before precharge ends
      drive(0, 0, 1, 1, 0);
      drive(1, 1, 1, 1, 1); after_edge();
      chk1("drop_idle_nras", nras, 1'b1);
      chk1("drop_idle_busy", busy, 1'b0);
      drive(1, 1, 1, 1, 1); after_edge();
      chk1("drop_idle2_nras", nras, 1'b1);

      // Asynchronous reset in the middle of a write CAS
      repeat (3) drive(0, 1, 0, 1, 0);
      after_edge();
      chk1("midcas_ncas", ncas, 1'b0);
      #1 rst = 1'b1;
      nmreq = 1'b1; nrd = 1'b1; nwr = 1'b1; nrfshd = 1'b1; nsltsl3 = 1'b1;
      #1;
      chk1("async_rst_nras", nras, 1'b1);
      chk1("async_rst_ncas", ncas, 1'b1);
      chk1("async_rst_mux", mux, 1'b0);
      chk1("async_rst_busy", busy, 1'b0);
      chk7("async_rst_row", rfsh_row, 7'd0);
      @(negedge clk) rst = 1'b0;
      model_reset();

      // Randomized bus activity
      r_nmreq = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         logic s_nrd, s_nwr, s_nrfshd, s_nsltsl3;
         if ($urandom_range(0, 3) == 0) r_nmreq = ~r_nmreq;
         s_nrd     = 1'($urandom_range(0, 1));
         s_nwr     = s_nrd ? 1'($urandom_range(0, 1)) : 1'b1;
         s_nrfshd  = ($urandom_range(0, 4) != 0);
         s_nsltsl3 = ($urandom_range(0, 2) == 0);
         drive(r_nmreq, s_nrd, s_nwr, s_nrfshd, s_nsltsl3);
      end
      drive(1, 1, 1, 1, 1);

      repeat (3) @(posedge clk);
      #3;
      chk7("queue_drained", 7'(exp_q.size()), 7'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
